// File: rtl/serial_word_shifter.sv
// Parallel-to-serial word shifter: first bit is on dataout the cycle after the load edge, one bit per clk.
// load_ready is high in IDLE, and also on the last bit when GAP=0 so back-to-back words stream with no idle bit.
module serial_word_shifter #(
    parameter int   WIDTH      = 8,
    parameter int   GAP        = 0,
    parameter logic IDLE_LEVEL = 1'b1,
    parameter bit   MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dataout,
    output logic             busy,
    output logic             word_done
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_BIT = CW'(WIDTH - 2);
    localparam logic [GW-1:0] LAST_GAP   = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_bit_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_dataout;
    logic             r_busy;
    logic             r_word_done;

    logic             w_last;
    logic             w_load_ready;
    logic             w_xfer;
    logic             w_first_bit;
    logic [WIDTH-1:0] w_load_rest;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shift_rest;

    assign w_last       = (r_state == S_SHIFT) && (r_bit_cnt == LAST_BIT);
    assign w_load_ready = !reset && ((r_state == S_IDLE) || ((GAP == 0) && w_last));
    assign w_xfer       = load_valid && w_load_ready;

    // The register holds only the bits not yet on the line, pre-shifted toward the output end.
    assign w_first_bit  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    assign w_load_rest  = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
    assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_shift_rest = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_shift     <= '0;
            r_dataout   <= IDLE_LEVEL;
            r_busy      <= 1'b0;
            r_word_done <= 1'b0;
        end else if (w_xfer) begin
            r_state     <= S_SHIFT;
            r_bit_cnt   <= '0;
            r_shift     <= w_load_rest;
            r_dataout   <= w_first_bit;
            r_busy      <= 1'b1;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_dataout <= IDLE_LEVEL;
                    r_busy    <= 1'b0;
                end
                S_SHIFT: begin
                    if (!w_last) begin
                        r_bit_cnt   <= r_bit_cnt + 1'b1;
                        r_shift     <= w_shift_rest;
                        r_dataout   <= w_next_bit;
                        r_word_done <= (r_bit_cnt == PENULT_BIT);
                    end else if (GAP > 0) begin
                        r_state   <= S_GAP;
                        r_bit_cnt <= '0;
                        r_gap_cnt <= '0;
                        r_dataout <= IDLE_LEVEL;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state   <= S_IDLE;
                        r_bit_cnt <= '0;
                        r_dataout <= IDLE_LEVEL;
                        r_busy    <= 1'b0;
                    end
                end
                S_GAP: begin
                    r_dataout <= IDLE_LEVEL;
                    if (r_gap_cnt == LAST_GAP) begin
                        r_state   <= S_IDLE;
                        r_gap_cnt <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_dataout <= IDLE_LEVEL;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = w_load_ready;
    assign dataout    = r_dataout;
    assign busy       = r_busy;
    assign word_done  = r_word_done;

endmodule

// File: tb/tb_serial_word_shifter.sv
// Directed bench: expected bits are queued when a word is handed over and popped as it appears on dataout.
module tb_serial_word_shifter;
    logic       clk;
    logic       reset;
    logic [7:0] ld   [3];
    logic       lv   [3];
    logic       lr   [3];
    logic       dout [3];
    logic       bsy  [3];
    logic       wd   [3];

    typedef struct packed {
        logic d;
        logic wd;
        logic lr;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Instance 0: defaults; 1: three-cycle gap; 2: LSB first.
    serial_word_shifter #(.WIDTH(8), .GAP(0), .IDLE_LEVEL(1'b1), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(reset), .load_data(ld[0]), .load_valid(lv[0]), .load_ready(lr[0]),
        .dataout(dout[0]), .busy(bsy[0]), .word_done(wd[0]));
    serial_word_shifter #(.WIDTH(8), .GAP(3), .IDLE_LEVEL(1'b1), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .load_data(ld[1]), .load_valid(lv[1]), .load_ready(lr[1]),
        .dataout(dout[1]), .busy(bsy[1]), .word_done(wd[1]));
    serial_word_shifter #(.WIDTH(8), .GAP(0), .IDLE_LEVEL(1'b1), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .reset(reset), .load_data(ld[2]), .load_valid(lv[2]), .load_ready(lr[2]),
        .dataout(dout[2]), .busy(bsy[2]), .word_done(wd[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_word(input logic [7:0] w, input bit msb, input bit gap0);
        exp_t e;
        for (int b = 0; b < 8; b++) begin
            e.d  = msb ? w[7-b] : w[b];
            e.wd = (b == 7);
            e.lr = gap0 && (b == 7);
            q.push_back(e);
        end
    endtask

    task automatic chk_bit(input int i, input string tag);
        exp_t e;
        total++;
        assert (q.size() != 0) else begin
            bad++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, "_d"}, dout[i], e.d);
            chk({tag, "_wd"}, wd[i], e.wd);
            chk({tag, "_lr"}, lr[i], e.lr);
            chk({tag, "_busy"}, bsy[i], 1'b1);
        end
    endtask

    task automatic chk_idle(input int i, input string tag);
        chk({tag, "_d"}, dout[i], 1'b1);
        chk({tag, "_busy"}, bsy[i], 1'b0);
        chk({tag, "_wd"}, wd[i], 1'b0);
        chk({tag, "_lr"}, lr[i], 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld[i] = 8'h00;
            lv[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_d", dout[i], 1'b1);
            chk("rst_busy", bsy[i], 1'b0);
            chk("rst_wd", wd[i], 1'b0);
            chk("rst_lr", lr[i], 1'b0);
        end
        reset = 1'b0;
        #1;
        for (int c = 0; c < 20; c++) begin
            chk_idle(0, "idle20");
            tick();
        end
        reset = 1'b1;
        #1 chk("rst_again_lr", lr[0], 1'b0);
        tick();
        reset = 1'b0;
        #1 chk_idle(0, "post_rst");

        // Single word, MSB first
        ld[0] = 8'hB2; lv[0] = 1'b1;
        push_word(8'hB2, 1'b1, 1'b1);
        chk("b2_xfer_lr", lr[0], 1'b1);
        tick();
        lv[0] = 1'b0; ld[0] = 8'h4D;
        for (int k = 0; k < 8; k++) begin
            chk_bit(0, "b2");
            tick();
        end
        chk_idle(0, "b2_after");

        // Back-to-back with load_valid held
        ld[0] = 8'hF0; lv[0] = 1'b1;
        push_word(8'hF0, 1'b1, 1'b1);
        chk("b2b_xfer_lr", lr[0], 1'b1);
        tick();
        for (int k = 0; k < 16; k++) begin
            if (k == 7) begin
                ld[0] = 8'h0F;
                push_word(8'h0F, 1'b1, 1'b1);
            end
            if (k == 8) lv[0] = 1'b0;
            chk_bit(0, "b2b");
            tick();
        end
        chk_idle(0, "b2b_after");

        // Gap of three cycles; a word offered during the gap waits
        ld[1] = 8'h01; lv[1] = 1'b1;
        push_word(8'h01, 1'b1, 1'b0);
        chk("gap_xfer_lr", lr[1], 1'b1);
        tick();
        lv[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_bit(1, "gap_w1");
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            if (g == 0) begin
                ld[1] = 8'hC3; lv[1] = 1'b1;
            end
            chk("gap_d", dout[1], 1'b1);
            chk("gap_busy", bsy[1], 1'b1);
            chk("gap_lr", lr[1], 1'b0);
            chk("gap_wd", wd[1], 1'b0);
            tick();
        end
        chk_idle(1, "gap_cyc12");
        push_word(8'hC3, 1'b1, 1'b0);
        tick();
        lv[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_bit(1, "gap_w2");
            tick();
        end
        repeat (3) tick();
        chk_idle(1, "gap_end");

        // LSB first
        ld[2] = 8'hB2; lv[2] = 1'b1;
        push_word(8'hB2, 1'b0, 1'b1);
        chk("lsb_xfer_lr", lr[2], 1'b1);
        tick();
        lv[2] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_bit(2, "lsb");
            tick();
        end
        chk_idle(2, "lsb_after");

        // Reset while bit 4 of 8'hAA is on the line
        ld[0] = 8'hAA; lv[0] = 1'b1;
        push_word(8'hAA, 1'b1, 1'b1);
        tick();
        lv[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_bit(0, "abort");
            if (k < 4) tick();
        end
        reset = 1'b1;
        tick();
        chk("abort_d", dout[0], 1'b1);
        chk("abort_busy", bsy[0], 1'b0);
        chk("abort_wd", wd[0], 1'b0);
        chk("abort_lr", lr[0], 1'b0);
        q.delete();
        reset = 1'b0;
        #1 chk_idle(0, "abort_rel");
        ld[0] = 8'h55; lv[0] = 1'b1;
        push_word(8'h55, 1'b1, 1'b1);
        tick();
        lv[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_bit(0, "after_abort");
            tick();
        end
        chk_idle(0, "final");
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
